// File: rtl/fight_referee.sv
// fight_referee: match controller that detects knock-outs and round timeouts, scores rounds and declares the match winner.
// It also drives the shared active-low reset of both player blocks.
module fight_referee #(
    parameter int ROUND_TICKS   = 30,
    parameter int START_DELAY   = 3,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] left_health,
    input  logic [2:0] right_health,
    input  logic [2:0] left_location,
    input  logic [2:0] right_location,
    output logic       players_rst_n,
    output logic       round_active,
    output logic [5:0] time_left,
    output logic [2:0] round_count,
    output logic [1:0] left_wins,
    output logic [1:0] right_wins,
    output logic [1:0] round_winner,
    output logic       match_over,
    output logic [1:0] match_winner
);
    typedef enum logic [2:0] {IDLE, COUNTDOWN, FIGHT, ROUND_END, MATCH_OVER} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] prev_l, prev_r, prev_l_n, prev_r_n;
    logic [5:0] time_left_n;
    logic [2:0] round_count_n;
    logic [1:0] left_wins_n, right_wins_n, round_winner_n, match_winner_n;
    logic       ko_l, ko_r;
    logic [1:0] to_res, res;

    // A jump of more than +1 can only be a 3-bit underflow wrap, so it counts as a KO.
    always_comb begin
        ko_l = (left_health == 3'd0) || ({1'b0, left_health} > {1'b0, prev_l} + 4'd1);
        ko_r = (right_health == 3'd0) || ({1'b0, right_health} > {1'b0, prev_r} + 4'd1);
        to_res = (left_health > right_health) ? 2'b01 :
                 (left_health < right_health) ? 2'b10 :
                 (left_location < right_location) ? 2'b01 :
                 (left_location > right_location) ? 2'b10 : 2'b11;
        res = (ko_l || ko_r) ? {ko_l, ko_r} : (time_left == 6'd1) ? to_res : 2'b00;
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        prev_l_n       = prev_l;
        prev_r_n       = prev_r;
        time_left_n    = time_left;
        round_count_n  = round_count;
        left_wins_n    = left_wins;
        right_wins_n   = right_wins;
        round_winner_n = round_winner;
        match_winner_n = match_winner;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = COUNTDOWN;
                    cnt_n   = 4'(START_DELAY);
                end
            end
            COUNTDOWN: begin
                if (cnt <= 4'd1) begin
                    state_n     = FIGHT;
                    time_left_n = 6'(ROUND_TICKS);
                    prev_l_n    = 3'd3;
                    prev_r_n    = 3'd3;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            FIGHT: begin
                prev_l_n = left_health;
                prev_r_n = right_health;
                if (res != 2'b00) begin
                    state_n        = ROUND_END;
                    round_winner_n = res;
                    round_count_n  = round_count + 3'd1;
                    left_wins_n    = (res == 2'b01) ? left_wins + 2'd1 : left_wins;
                    right_wins_n   = (res == 2'b10) ? right_wins + 2'd1 : right_wins;
                end else begin
                    time_left_n = time_left - 6'd1;
                end
            end
            ROUND_END: begin
                if (left_wins == 2'(ROUNDS_TO_WIN)) begin
                    state_n        = MATCH_OVER;
                    match_winner_n = 2'b01;
                end else if (right_wins == 2'(ROUNDS_TO_WIN)) begin
                    state_n        = MATCH_OVER;
                    match_winner_n = 2'b10;
                end else if (round_count == 3'(MAX_ROUNDS)) begin
                    state_n        = MATCH_OVER;
                    match_winner_n = (left_wins > right_wins) ? 2'b01 :
                                     (left_wins < right_wins) ? 2'b10 : 2'b11;
                end else begin
                    state_n = COUNTDOWN;
                    cnt_n   = 4'(START_DELAY);
                end
            end
            MATCH_OVER: begin
                if (start) begin
                    state_n        = COUNTDOWN;
                    cnt_n          = 4'(START_DELAY);
                    round_count_n  = 3'd0;
                    left_wins_n    = 2'd0;
                    right_wins_n   = 2'd0;
                    round_winner_n = 2'b00;
                    match_winner_n = 2'b00;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Status outputs are registered straight from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            prev_l        <= 3'd3;
            prev_r        <= 3'd3;
            players_rst_n <= 1'b0;
            round_active  <= 1'b0;
            time_left     <= 6'd0;
            round_count   <= 3'd0;
            left_wins     <= 2'd0;
            right_wins    <= 2'd0;
            round_winner  <= 2'b00;
            match_over    <= 1'b0;
            match_winner  <= 2'b00;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            prev_l        <= prev_l_n;
            prev_r        <= prev_r_n;
            players_rst_n <= (state_n == FIGHT);
            round_active  <= (state_n == FIGHT);
            time_left     <= time_left_n;
            round_count   <= round_count_n;
            left_wins     <= left_wins_n;
            right_wins    <= right_wins_n;
            round_winner  <= round_winner_n;
            match_over    <= (state_n == MATCH_OVER);
            match_winner  <= match_winner_n;
        end
    end
endmodule
